uart_cmd_seq: RTL and testbench

Sequencer between the UART byte datapath (UART_rx / UART_tx) and the application logic.
- Receive side: collects three consecutive received bytes into a 24-bit command, MSB first, and raises cmd_rdy.
- Transmit side: serialises a 16-bit response into two trmt/tx_done byte transactions, high byte first.
- Owns all handshakes with the UART so that application logic sees only word-level requests.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_resp_tx.sv | 100 ++++++++++
 rtl/uart_cmd_seq.sv | 133 +++++++++++++
 tb/tb_uart_cmd_seq.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART command sequencer.
//   rx_state_t : receive-side byte collector states
//   tx_state_t : transmit-side response serialiser states
//   CLKS_PER_BIT, CMD_BYTES, DEFAULT_TIMEOUT_CLKS : sizing constants
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int CLKS_PER_BIT = 2604;
  localparam int CMD_BYTES = 3;
  // Twenty bit times of silence between bytes ends a partial command.
  localparam int DEFAULT_TIMEOUT_CLKS = 20 * CLKS_PER_BIT;

  typedef enum logic {
    RX_WAIT,
    RX_CLR
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_HI_ARM,
    TX_HI_WAIT,
    TX_LO_ARM,
    TX_LO_WAIT
  } tx_state_t;

endpackage

// File: rtl/uart_resp_tx.sv
// -----------------------------------------------------------------------------
// uart_resp_tx
// Serialises a 16-bit response word into two UART_tx byte transactions,
// high byte first, using the trmt / tx_done handshake.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   resp         : response word, latched when send_resp is accepted
//   send_resp    : request to transmit resp (ignored while tx_busy)
//   tx_done      : UART_tx done, high until the next trmt
//   tx_data      : byte presented to UART_tx, held between bytes
//   trmt         : one-cycle start pulse for UART_tx
//   tx_busy      : high from acceptance until the low byte completes
//   resp_sent    : one-cycle pulse when the low byte has completed
// -----------------------------------------------------------------------------
module uart_resp_tx
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] resp,
  input  logic        send_resp,
  input  logic        tx_done,
  output logic [7:0]  tx_data,
  output logic        trmt,
  output logic        tx_busy,
  output logic        resp_sent
);

  tx_state_t   r_state, w_nextState;
  logic [15:0] r_resp, w_nextResp;
  logic [7:0]  r_txData, w_nextTxData;
  logic        r_trmt, w_nextTrmt;
  logic        r_busy, w_nextBusy;
  logic        r_respSent, w_nextRespSent;

  // State and registered handshake outputs; trmt is registered so it lines
  // up with the tx_data value it launches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= TX_IDLE;
      r_resp     <= '0;
      r_txData   <= '0;
      r_trmt     <= 1'b0;
      r_busy     <= 1'b0;
      r_respSent <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_resp     <= w_nextResp;
      r_txData   <= w_nextTxData;
      r_trmt     <= w_nextTrmt;
      r_busy     <= w_nextBusy;
      r_respSent <= w_nextRespSent;
    end
  end

  // The ARM states spend one cycle after each trmt so that the tx_done
  // still high from the previous byte is not mistaken for completion.
  always_comb begin
    w_nextState    = r_state;
    w_nextResp     = r_resp;
    w_nextTxData   = r_txData;
    w_nextTrmt     = 1'b0;
    w_nextBusy     = r_busy;
    w_nextRespSent = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (send_resp) begin
          w_nextResp   = resp;
          w_nextTxData = resp[15:8];
          w_nextTrmt   = 1'b1;
          w_nextBusy   = 1'b1;
          w_nextState  = TX_HI_ARM;
        end
      end
      TX_HI_ARM: w_nextState = TX_HI_WAIT;
      TX_HI_WAIT: begin
        if (tx_done) begin
          w_nextTxData = r_resp[7:0];
          w_nextTrmt   = 1'b1;
          w_nextState  = TX_LO_ARM;
        end
      end
      TX_LO_ARM: w_nextState = TX_LO_WAIT;
      TX_LO_WAIT: begin
        if (tx_done) begin
          w_nextRespSent = 1'b1;
          w_nextBusy     = 1'b0;
          w_nextState    = TX_IDLE;
        end
      end
      default: w_nextState = TX_IDLE;
    endcase
  end

  assign tx_data   = r_txData;
  assign trmt      = r_trmt;
  assign tx_busy   = r_busy;
  assign resp_sent = r_respSent;

endmodule

// File: rtl/uart_cmd_seq.sv
// -----------------------------------------------------------------------------
// uart_cmd_seq
// Sequencer between the UART byte datapath and application logic.
// Receive side collects three bytes (MSB first) into a 24-bit command with a
// sticky cmd_rdy; transmit side sends a 16-bit response as two bytes.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   rx_data, rx_rdy          : byte and valid from UART_rx
//   clr_rx_rdy               : pulse clearing UART_rx rdy on capture
//   tx_data, trmt, tx_done   : byte interface to UART_tx
//   cmd, cmd_rdy             : assembled command and sticky valid
//   clr_cmd_rdy              : consumer acknowledge for cmd_rdy
//   resp, send_resp          : response word and transmit request
//   tx_busy, resp_sent       : response transfer status
// -----------------------------------------------------------------------------
module uart_cmd_seq
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [15:0] resp,
  input  logic        send_resp,
  output logic        tx_busy,
  output logic        resp_sent
);

  rx_state_t        r_rxState, w_nextRxState;
  logic [23:0]      r_cmd, w_nextCmd;
  logic [1:0]       r_byteCnt, w_nextByteCnt;
  logic [CNT_W-1:0] r_toCnt, w_nextToCnt;
  logic             r_cmdRdy, w_nextCmdRdy;
  logic             w_capture;
  logic             w_lastByte;
  logic             w_timeout;

  // Capture happens only in WAIT; gated by rst_n so the pulse cannot
  // appear while the block is held in reset.
  assign w_capture  = rst_n && (r_rxState == RX_WAIT) && rx_rdy;
  assign w_lastByte = (r_byteCnt == 2'(CMD_BYTES - 1));
  assign w_timeout  = (r_toCnt == CNT_W'(TIMEOUT_CLKS));

  // Receive collector state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxState <= RX_WAIT;
      r_cmd     <= '0;
      r_byteCnt <= '0;
      r_toCnt   <= '0;
      r_cmdRdy  <= 1'b0;
    end else begin
      r_rxState <= w_nextRxState;
      r_cmd     <= w_nextCmd;
      r_byteCnt <= w_nextByteCnt;
      r_toCnt   <= w_nextToCnt;
      r_cmdRdy  <= w_nextCmdRdy;
    end
  end

  // Byte shifting, command completion and inter-byte timeout. CLR lingers
  // until rx_rdy drops, so a slowly-clearing rdy yields one capture only;
  // with a normal UART_rx this is a single dead cycle. A completing capture
  // is assigned after the acknowledge so the set wins a collision.
  always_comb begin
    w_nextRxState = r_rxState;
    w_nextCmd     = r_cmd;
    w_nextByteCnt = r_byteCnt;
    w_nextToCnt   = r_toCnt;
    w_nextCmdRdy  = r_cmdRdy;
    if (clr_cmd_rdy) begin
      w_nextCmdRdy = 1'b0;
    end
    case (r_rxState)
      RX_WAIT: begin
        if (rx_rdy) begin
          w_nextCmd     = {r_cmd[15:0], rx_data};
          w_nextToCnt   = '0;
          w_nextRxState = RX_CLR;
          if (w_lastByte) begin
            w_nextByteCnt = '0;
            w_nextCmdRdy  = 1'b1;
          end else begin
            w_nextByteCnt = r_byteCnt + 2'd1;
            if (r_byteCnt == 2'd0) begin
              w_nextCmdRdy = 1'b0;
            end
          end
        end else if (r_byteCnt != 2'd0) begin
          if (w_timeout) begin
            w_nextByteCnt = '0;
            w_nextToCnt   = '0;
          end else begin
            w_nextToCnt = r_toCnt + CNT_W'(1);
          end
        end
      end
      RX_CLR: begin
        if (!rx_rdy) begin
          w_nextRxState = RX_WAIT;
        end
      end
      default: w_nextRxState = RX_WAIT;
    endcase
  end

  assign clr_rx_rdy = w_capture;
  assign cmd        = r_cmd;
  assign cmd_rdy    = r_cmdRdy;

  uart_resp_tx u_respTx (
    .clk       (clk),
    .rst_n     (rst_n),
    .resp      (resp),
    .send_resp (send_resp),
    .tx_done   (tx_done),
    .tx_data   (tx_data),
    .trmt      (trmt),
    .tx_busy   (tx_busy),
    .resp_sent (resp_sent)
  );

endmodule

// File: tb/tb_uart_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_seq
// Self-checking bench for uart_cmd_seq. A behavioural UART_tx stand-in drives
// tx_done and logs every launched byte; commands and responses are compared
// against word-level expectations built in the bench.
// -----------------------------------------------------------------------------
module tb_uart_cmd_seq;

  localparam int TB_TIMEOUT = 2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rx_rdy;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [15:0] resp;
  logic        send_resp;
  logic        tx_busy;
  logic        resp_sent;

  int vectors = 0;
  int miscompares = 0;
  int clrCount = 0;
  int trmtCount = 0;
  int respSentCount = 0;
  int txCountdown = 0;
  logic [7:0] txLog[$];

  always #5 clk = ~clk;

  uart_cmd_seq #(
    .TIMEOUT_CLKS (TB_TIMEOUT),
    .CNT_W        (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_rdy      (rx_rdy),
    .clr_rx_rdy  (clr_rx_rdy),
    .tx_data     (tx_data),
    .trmt        (trmt),
    .tx_done     (tx_done),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .tx_busy     (tx_busy),
    .resp_sent   (resp_sent)
  );

  // UART_tx stand-in and pulse monitor: tx_done drops on trmt and returns
  // after a random byte time; every trmt byte and pulse is recorded.
  initial begin
    tx_done = 1'b1;
    forever begin
      @(negedge clk);
      #3;
      if (clr_rx_rdy) clrCount++;
      if (resp_sent) respSentCount++;
      if (txCountdown > 0) begin
        txCountdown--;
        if (txCountdown == 0) tx_done = 1'b1;
      end
      if (trmt) begin
        trmtCount++;
        txLog.push_back(tx_data);
        tx_done = 1'b0;
        txCountdown = $urandom_range(3, 10);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang required finish");
    $fatal(1, "[TB] watchdog");
  end

  // Presents one byte like UART_rx: rdy stays up until clr_rx_rdy is seen,
  // then drops after that clock edge. Returns half a cycle after capture.
  task automatic applyRxByte(input logic [7:0] b, input bit clrToo);
    int budget;
    @(negedge clk);
    rx_data = b;
    rx_rdy = 1'b1;
    clr_cmd_rdy = clrToo;
    #1;
    budget = 0;
    while (!clr_rx_rdy && budget < 20) begin
      @(negedge clk);
      #1;
      budget++;
    end
    vectors++;
    if (!clr_rx_rdy) begin
      miscompares++;
      $display("[TB] FAIL rx_capture_wait: clr_rx_rdy got 0 required 1 for byte %h", b);
    end
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic applyResp(input logic [15:0] w);
    @(negedge clk);
    resp = w;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    resp = 16'($urandom);
  endtask

  task automatic waitTxIdle(input string tag);
    int budget;
    budget = 0;
    while (tx_busy && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    vectors++;
    if (tx_busy) begin
      miscompares++;
      $display("[TB] FAIL %s_idle_wait: tx_busy got 1 required 0", tag);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rx_rdy = 1'b1;
    rx_data = 8'h77;
    send_resp = 1'b1;
    resp = 16'h1234;
    repeat (3) @(negedge clk);
    vectors++;
    if ({clr_rx_rdy, trmt, tx_busy, resp_sent, cmd_rdy} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b required 00000",
               {clr_rx_rdy, trmt, tx_busy, resp_sent, cmd_rdy});
    end
    vectors++;
    if (tx_data !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_tx_data: got %h required 00", tx_data);
    end
    vectors++;
    if (cmd !== 24'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_cmd: got %h required 000000", cmd);
    end
    rx_rdy = 1'b0;
    send_resp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (trmtCount !== 0 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release_idle: trmt count %0d busy %b required 0 0",
               trmtCount, tx_busy);
    end
  endtask

  task automatic test_reset_midway();
    int trmtBefore, sentBefore;
    applyRxByte(8'h99, 1'b0);
    sentBefore = respSentCount;
    trmtBefore = trmtCount;
    applyResp(16'hC0DE);
    @(negedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({clr_rx_rdy, trmt, tx_busy, resp_sent, cmd_rdy} !== 5'b0 || tx_data !== 8'h00
        || cmd !== 24'h0) begin
      miscompares++;
      $display("[TB] FAIL midway_reset_outputs: flags %b tx_data %h cmd %h required all 0",
               {clr_rx_rdy, trmt, tx_busy, resp_sent, cmd_rdy}, tx_data, cmd);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    vectors++;
    if (trmtCount !== trmtBefore + 1 || respSentCount !== sentBefore) begin
      miscompares++;
      $display("[TB] FAIL midway_no_resume: trmt %0d resp_sent %0d required %0d %0d",
               trmtCount - trmtBefore, respSentCount - sentBefore, 1, 0);
    end
    applyRxByte(8'hA1, 1'b0);
    applyRxByte(8'hA2, 1'b0);
    vectors++;
    if (cmd_rdy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midway_partial_dropped: cmd_rdy got %b required 0", cmd_rdy);
    end
    applyRxByte(8'hA3, 1'b0);
    vectors++;
    if (cmd_rdy !== 1'b1 || cmd !== 24'hA1A2A3) begin
      miscompares++;
      $display("[TB] FAIL midway_new_cmd: cmd %h rdy %b required A1A2A3 1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_basic_cmd();
    int clrBefore;
    clrBefore = clrCount;
    applyRxByte(8'h3A, 1'b0);
    vectors++;
    if (cmd_rdy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_first_byte_clears: cmd_rdy got %b required 0", cmd_rdy);
    end
    applyRxByte(8'hC5, 1'b0);
    applyRxByte(8'h0F, 1'b0);
    vectors++;
    if (cmd_rdy !== 1'b1 || cmd !== 24'h3AC50F) begin
      miscompares++;
      $display("[TB] FAIL basic_cmd: cmd %h rdy %b required 3AC50F 1", cmd, cmd_rdy);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (clrCount - clrBefore !== 3) begin
      miscompares++;
      $display("[TB] FAIL basic_clr_pulses: got %0d required 3", clrCount - clrBefore);
    end
  endtask

  task automatic test_held_rdy();
    int clrBefore;
    clrBefore = clrCount;
    @(negedge clk);
    rx_data = 8'h55;
    rx_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (clrCount - clrBefore !== 1) begin
      miscompares++;
      $display("[TB] FAIL held_rdy_pulses: got %0d required 1", clrCount - clrBefore);
    end
    applyRxByte(8'h66, 1'b0);
    vectors++;
    if (cmd_rdy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL held_rdy_single_capture: cmd_rdy got %b required 0", cmd_rdy);
    end
    applyRxByte(8'h77, 1'b0);
    vectors++;
    if (cmd_rdy !== 1'b1 || cmd !== 24'h556677) begin
      miscompares++;
      $display("[TB] FAIL held_rdy_cmd: cmd %h rdy %b required 556677 1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_resp();
    int trmtBefore, sentBefore;
    txLog.delete();
    trmtBefore = trmtCount;
    sentBefore = respSentCount;
    applyResp(16'hBEEF);
    vectors++;
    if (trmt !== 1'b1 || tx_data !== 8'hBE || tx_busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL resp_accept: trmt %b tx_data %h busy %b required 1 BE 1",
               trmt, tx_data, tx_busy);
    end
    resp = 16'h5151;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    waitTxIdle("resp");
    repeat (15) @(negedge clk);
    vectors++;
    if (txLog.size() !== 2 || trmtCount - trmtBefore !== 2) begin
      miscompares++;
      $display("[TB] FAIL resp_byte_count: got %0d bytes required 2", txLog.size());
    end else begin
      vectors++;
      if ({txLog[0], txLog[1]} !== 16'hBEEF) begin
        miscompares++;
        $display("[TB] FAIL resp_bytes: got %h%h required BEEF", txLog[0], txLog[1]);
      end
    end
    vectors++;
    if (respSentCount - sentBefore !== 1 || tx_data !== 8'hEF) begin
      miscompares++;
      $display("[TB] FAIL resp_sent_pulse: pulses %0d tx_data %h required 1 EF",
               respSentCount - sentBefore, tx_data);
    end
  endtask

  task automatic test_timeout();
    applyRxByte(8'h01, 1'b0);
    repeat (TB_TIMEOUT - 20) @(negedge clk);
    applyRxByte(8'h02, 1'b0);
    applyRxByte(8'h03, 1'b0);
    vectors++;
    if (cmd_rdy !== 1'b1 || cmd !== 24'h010203) begin
      miscompares++;
      $display("[TB] FAIL timeout_short_gap: cmd %h rdy %b required 010203 1", cmd, cmd_rdy);
    end
    applyRxByte(8'h11, 1'b0);
    applyRxByte(8'h22, 1'b0);
    repeat (TB_TIMEOUT + 20) @(negedge clk);
    applyRxByte(8'hAA, 1'b0);
    vectors++;
    if (cmd_rdy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_discard: cmd_rdy got %b required 0 cmd %h", cmd_rdy, cmd);
    end
    applyRxByte(8'hBB, 1'b0);
    applyRxByte(8'hCC, 1'b0);
    vectors++;
    if (cmd_rdy !== 1'b1 || cmd !== 24'hAABBCC) begin
      miscompares++;
      $display("[TB] FAIL timeout_new_cmd: cmd %h rdy %b required AABBCC 1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_clr_collision();
    applyRxByte(8'h01, 1'b0);
    applyRxByte(8'h02, 1'b0);
    applyRxByte(8'h03, 1'b0);
    applyRxByte(8'h04, 1'b0);
    applyRxByte(8'h05, 1'b0);
    applyRxByte(8'h06, 1'b1);
    vectors++;
    if (cmd_rdy !== 1'b1 || cmd !== 24'h040506) begin
      miscompares++;
      $display("[TB] FAIL collision_set_wins: cmd %h rdy %b required 040506 1", cmd, cmd_rdy);
    end
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    vectors++;
    if (cmd_rdy !== 1'b0 || cmd !== 24'h040506) begin
      miscompares++;
      $display("[TB] FAIL collision_ack: cmd %h rdy %b required 040506 0", cmd, cmd_rdy);
    end
  endtask

  task automatic test_random_cmds();
    logic [7:0]  bytes[$];
    logic [7:0]  b;
    logic [23:0] expCmd;
    for (int n = 0; n < 24; n++) begin
      bytes.delete();
      for (int k = 0; k < 3; k++) begin
        b = 8'($urandom);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        applyRxByte(b, ($urandom_range(0, 3) == 0));
        bytes.push_back(b);
        if (k < 2) begin
          vectors++;
          if (cmd_rdy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL random_partial_%0d: cmd_rdy got %b required 0", n, cmd_rdy);
          end
        end
      end
      expCmd = {bytes[0], bytes[1], bytes[2]};
      vectors++;
      if (cmd_rdy !== 1'b1 || cmd !== expCmd) begin
        miscompares++;
        $display("[TB] FAIL random_cmd_%0d: cmd %h rdy %b required %h 1", n, cmd, cmd_rdy, expCmd);
      end
      if ($urandom_range(0, 1) == 1) begin
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        vectors++;
        if (cmd_rdy !== 1'b0 || cmd !== expCmd) begin
          miscompares++;
          $display("[TB] FAIL random_ack_%0d: cmd %h rdy %b required %h 0", n, cmd, cmd_rdy, expCmd);
        end
      end
    end
  endtask

  task automatic test_random_resp();
    logic [15:0] w;
    int sentBefore;
    for (int n = 0; n < 8; n++) begin
      w = 16'($urandom);
      txLog.delete();
      sentBefore = respSentCount;
      applyResp(w);
      if ($urandom_range(0, 1) == 1) begin
        resp = ~w;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
      end
      waitTxIdle("random_resp");
      vectors++;
      if (txLog.size() !== 2 || respSentCount - sentBefore !== 1) begin
        miscompares++;
        $display("[TB] FAIL random_resp_count_%0d: bytes %0d pulses %0d required 2 1",
                 n, txLog.size(), respSentCount - sentBefore);
      end else begin
        vectors++;
        if ({txLog[0], txLog[1]} !== w) begin
          miscompares++;
          $display("[TB] FAIL random_resp_%0d: got %h%h required %h", n, txLog[0], txLog[1], w);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    w = 16'hA5C3;
    txLog.delete();
    @(negedge clk);
    rx_data = 8'h5A;
    rx_rdy = 1'b1;
    resp = w;
    send_resp = 1'b1;
    #1;
    vectors++;
    if (clr_rx_rdy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_rx_capture: clr_rx_rdy got %b required 1", clr_rx_rdy);
    end
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    send_resp = 1'b0;
    vectors++;
    if (trmt !== 1'b1 || tx_data !== w[15:8] || tx_busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_tx_accept: trmt %b tx_data %h busy %b required 1 %h 1",
               trmt, tx_data, tx_busy, w[15:8]);
    end
    @(negedge clk);
    waitTxIdle("b2b");
    vectors++;
    if (txLog.size() !== 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_resp_count: got %0d bytes required 2", txLog.size());
    end else begin
      vectors++;
      if ({txLog[0], txLog[1]} !== w) begin
        miscompares++;
        $display("[TB] FAIL b2b_resp: got %h%h required %h", txLog[0], txLog[1], w);
      end
    end
    applyRxByte(8'h6B, 1'b0);
    applyRxByte(8'h7C, 1'b0);
    vectors++;
    if (cmd_rdy !== 1'b1 || cmd !== 24'h5A6B7C) begin
      miscompares++;
      $display("[TB] FAIL b2b_cmd: cmd %h rdy %b required 5A6B7C 1", cmd, cmd_rdy);
    end
  endtask

  // Scenario sequence.
  initial begin
    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_rdy = 1'b0;
    clr_cmd_rdy = 1'b0;
    resp = 16'h0000;
    send_resp = 1'b0;
    test_reset();
    test_reset_midway();
    test_basic_cmd();
    test_held_rdy();
    test_resp();
    test_timeout();
    test_clr_collision();
    test_random_cmds();
    test_random_resp();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
